pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/otter_hazard_pkg.sv | 27 ++
 rtl/hazard_fwd_unit.sv | 37 +++
 rtl/pipeline_hazard_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/otter_hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forward selects, scoreboard entries.
package otter_hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_EX = 2'b01,
    FWD_WB = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } sb_entry_t;

  // An in-flight writer only matters if it really writes, is not x0, and the operand is really read.
  function automatic logic sb_hit(input sb_entry_t ent, input logic [4:0] rs, input logic used);
    return ent.regwrite && (ent.rd != 5'd0) && (ent.rd == rs) && used;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Per-operand dependency compare against the EXS/MEMS scoreboard; yields a stall request and a forward select.
// Build option HAZARD_FWD_EN: forward from EX/WB; when undefined every dependency requests a stall.
module hazard_fwd_unit
  import otter_hazard_pkg::*;
(
  input  logic [4:0] rs_addr,
  input  logic       rs_used,
  input  sb_entry_t  exs,
  input  sb_entry_t  mems,
  output logic       stall_req,
  output fwd_sel_e   fwd_sel
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = sb_hit(exs, rs_addr, rs_used);
  assign mem_hit = sb_hit(mems, rs_addr, rs_used);

`ifdef HAZARD_FWD_EN
  // Load data is not available from the execute register, so only a load in EX forces a stall.
  assign stall_req = ex_hit && exs.memread;

  always_comb begin
    fwd_sel = FWD_RF;
    if (ex_hit && !exs.memread) begin
      fwd_sel = FWD_EX;
    end else if (mem_hit) begin
      fwd_sel = FWD_WB;
    end
  end
`else
  assign stall_req = ex_hit || mem_hit;
  assign fwd_sel   = FWD_RF;
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: load-use stall, redirect flush, operand forwarding and a saturating stall counter.
// Build option HAZARD_FWD_EN enables forwarding; without it any in-flight dependency stalls.
//
// state      | meaning
// RUN        | normal issue; redirect, stall and forwarding decided from decode + scoreboard
// LOAD_STALL | cycle after a stall; leaves once no stall request remains
// FLUSH      | bubbles after a taken redirect; EX_PCSOURCE ignored until the counter expires
module pipeline_hazard_ctrl
  import otter_hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             HZ_CLOCK,
  input  logic             HZ_RESET_N,
  input  logic [4:0]       DEC_RS1_ADDR,
  input  logic [4:0]       DEC_RS2_ADDR,
  input  logic             DEC_RS1_USED,
  input  logic             DEC_RS2_USED,
  input  logic [4:0]       DEC_RD_ADDR,
  input  logic             DEC_REG_WRITE,
  input  logic             DEC_MEM_READ2,
  input  logic [1:0]       EX_PCSOURCE,
  output logic             PC_STALL,
  output logic             DEC_STALL,
  output logic             EX_BUBBLE,
  output logic             FD_FLUSH,
  output logic [1:0]       FWD_A_SEL,
  output logic [1:0]       FWD_B_SEL,
  output logic [1:0]       HZ_STATE,
  output logic [CNT_W-1:0] HZ_STALL_CNT
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  hz_state_e        state_q;
  hz_state_e        state_d;
  logic [1:0]       flush_cnt_q;
  logic [1:0]       flush_cnt_d;
  sb_entry_t        exs_q;
  sb_entry_t        mems_q;
  sb_entry_t        dec_entry;
  logic [CNT_W-1:0] stall_cnt_q;

  logic     a_stall;
  logic     b_stall;
  fwd_sel_e a_sel;
  fwd_sel_e b_sel;
  logic     stall_req;
  logic     redirect;
  logic     pc_stall;
  logic     ex_bubble;
  logic     fd_flush;
  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;

  hazard_fwd_unit u_fwd_a (
    .rs_addr   (DEC_RS1_ADDR),
    .rs_used   (DEC_RS1_USED),
    .exs       (exs_q),
    .mems      (mems_q),
    .stall_req (a_stall),
    .fwd_sel   (a_sel)
  );

  hazard_fwd_unit u_fwd_b (
    .rs_addr   (DEC_RS2_ADDR),
    .rs_used   (DEC_RS2_USED),
    .exs       (exs_q),
    .mems      (mems_q),
    .stall_req (b_stall),
    .fwd_sel   (b_sel)
  );

  assign stall_req = a_stall | b_stall;
  assign redirect  = (EX_PCSOURCE != 2'b00);
  assign dec_entry = '{rd: DEC_RD_ADDR, regwrite: DEC_REG_WRITE, memread: DEC_MEM_READ2};

  always_comb begin
    pc_stall    = 1'b0;
    ex_bubble   = 1'b0;
    fd_flush    = 1'b0;
    fwd_a       = FWD_RF;
    fwd_b       = FWD_RF;
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      FLUSH: begin
        fd_flush  = 1'b1;
        ex_bubble = 1'b1;
        if (flush_cnt_q == 2'd0) begin
          state_d = RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 2'd1;
        end
      end
      default: begin
        // Redirect wins over load-use: the dependent instruction is on the wrong path anyway.
        if (redirect) begin
          fd_flush    = 1'b1;
          ex_bubble   = 1'b1;
          state_d     = FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end else if (stall_req) begin
          pc_stall  = 1'b1;
          ex_bubble = 1'b1;
          state_d   = LOAD_STALL;
        end else begin
          fwd_a   = a_sel;
          fwd_b   = b_sel;
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge HZ_CLOCK or negedge HZ_RESET_N) begin
    if (!HZ_RESET_N) begin
      state_q     <= RUN;
      flush_cnt_q <= 2'd0;
      exs_q       <= '0;
      mems_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      mems_q      <= exs_q;
      if (ex_bubble) begin
        exs_q <= '0;
      end else begin
        exs_q <= dec_entry;
      end
      if (pc_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  // Combinational outputs would otherwise follow EX_PCSOURCE/decode while reset is held.
  assign PC_STALL     = HZ_RESET_N & pc_stall;
  assign DEC_STALL    = HZ_RESET_N & pc_stall;
  assign EX_BUBBLE    = HZ_RESET_N & ex_bubble;
  assign FD_FLUSH     = HZ_RESET_N & fd_flush;
  assign FWD_A_SEL    = HZ_RESET_N ? fwd_a : FWD_RF;
  assign FWD_B_SEL    = HZ_RESET_N ? fwd_b : FWD_RF;
  assign HZ_STATE     = state_q;
  assign HZ_STALL_CNT = stall_cnt_q;

endmodule
